// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
//   Round-robin sequencer for a 4-to-1 mux. It steps the mux select over
//   the enabled channels and holds each select for DWELL cycles. At the end
//   of each dwell it registers the mux output together with its channel tag.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   en           scan enable
//   ch_mask      per-channel enable, bit i enables channel i
//   mux_in       mux output (WIDTH bits)
//   sel          registered select driven to the mux
//   sample       last captured mux value
//   sample_ch    channel index of sample
//   sample_valid one-cycle pulse when sample/sample_ch update
//   scan_done    one-cycle pulse with sample_valid on the last enabled channel
module mux_sel_scanner #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       ch_mask,
  input  logic [WIDTH-1:0] mux_in,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] sample,
  output logic [1:0]       sample_ch,
  output logic             sample_valid,
  output logic             scan_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [1:0]       sel_n;
  logic [WIDTH-1:0] sample_n;
  logic [1:0]       sample_ch_n;
  logic             valid_n, done_n;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 4; i > 0; i--)
      if (m[i-1]) r = 2'(i - 1);
    return r;
  endfunction

  // Search cur+1, cur+2, cur+3 and finally cur itself. The loop runs from
  // lowest to highest priority so the last hit wins.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r, idx;
    r = cur;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sel          <= '0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sel          <= sel_n;
      sample       <= sample_n;
      sample_ch    <= sample_ch_n;
      sample_valid <= valid_n;
      scan_done    <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel_n       = sel;
    sample_n    = sample;
    sample_ch_n = sample_ch;
    valid_n     = 1'b0;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (en && (ch_mask != '0)) begin
          sel_n   = lowest_ch(ch_mask);
          cnt_n   = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (ch_mask == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!ch_mask[sel]) begin
          sel_n = next_ch(ch_mask, sel);
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          sample_n    = mux_in;
          sample_ch_n = sel;
          valid_n     = 1'b1;
          // (2 << sel) - 1 masks channels 0..sel; anything left is above sel.
          done_n      = ~|(ch_mask & ~((4'd2 << sel) - 4'd1));
          cnt_n       = '0;
          if (en) sel_n = next_ch(ch_mask, sel);
          else    state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_scanner.sv
module tb_mux_sel_scanner;

  logic       clk, reset, en;
  logic [3:0] ch_mask;
  logic [3:0] mux_in;
  logic [1:0] sel;
  logic [3:0] sample;
  logic [1:0] sample_ch;
  logic       sample_valid, scan_done;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned b;

  typedef struct {
    logic [3:0]  s;
    logic [1:0]  ch;
    logic        done;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  exp_t e;

  mux_sel_scanner #(.WIDTH(4), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .en(en), .ch_mask(ch_mask), .mux_in(mux_in),
    .sel(sel), .sample(sample), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .scan_done(scan_done)
  );

  // Mux model: channel 0..3 carries 1..4.
  assign mux_in = {2'b00, sel} + 4'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [1:0] ch, input logic d,
                      input int unsigned at);
    exp_t x;
    x.s = s; x.ch = ch; x.done = d; x.at = at;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [3:0] m);
    @(negedge clk);
    #1;
    chk("pending_before_restart", q.size(), 0);
    q.delete();
    reset = 1'b1; en = 1'b1; ch_mask = m;
    step();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every sample_valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (scan_done && !sample_valid) chk("done_without_valid", 1, 0);
      if (sample_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sample", int'(sample), int'(e.s));
          chk("sample_ch", int'(sample_ch), int'(e.ch));
          chk("scan_done", int'(scan_done), int'(e.done));
          chk("valid_cycle", int'(cyc), int'(e.at));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required finish before 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; ch_mask = 4'b0000;
    step();
    chk("rst_sel", int'(sel), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_sample_ch", int'(sample_ch), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_done", int'(scan_done), 0);

    // All four channels enabled.
    restart(4'b1111);
    b = cyc;
    push(4'd1, 2'd0, 1'b0, b + 5);
    push(4'd2, 2'd1, 1'b0, b + 9);
    push(4'd3, 2'd2, 1'b0, b + 13);
    push(4'd4, 2'd3, 1'b1, b + 17);
    push(4'd1, 2'd0, 1'b0, b + 21);
    for (int i = 1; i <= 21; i++) begin
      step();
      chk("A_sel", int'(sel), ((i - 1) / 4) % 4);
    end

    // Channels 1 and 3 only; async reset mid-dwell on channel 3.
    restart(4'b1010);
    b = cyc;
    push(4'd2, 2'd1, 1'b0, b + 5);
    push(4'd4, 2'd3, 1'b1, b + 9);
    push(4'd2, 2'd1, 1'b0, b + 13);
    push(4'd4, 2'd3, 1'b1, b + 17);
    push(4'd2, 2'd1, 1'b0, b + 21);
    for (int i = 1; i <= 22; i++) begin
      step();
      chk("B_sel", int'(sel), (((i - 1) / 4) % 2 == 1) ? 3 : 1);
    end
    chk("B_pre_sample", int'(sample), 2);
    reset = 1'b1;
    #1;
    chk("B_async_sel", int'(sel), 0);
    chk("B_async_sample", int'(sample), 0);
    chk("B_async_sample_ch", int'(sample_ch), 0);
    chk("B_async_valid", int'(sample_valid), 0);
    chk("B_async_done", int'(scan_done), 0);
    step();
    reset = 1'b0;
    b = cyc;
    push(4'd2, 2'd1, 1'b0, b + 5);
    step();
    chk("B_restart_sel", int'(sel), 1);
    repeat (4) step();

    // Single channel re-selects itself.
    restart(4'b0100);
    b = cyc;
    push(4'd3, 2'd2, 1'b1, b + 5);
    push(4'd3, 2'd2, 1'b1, b + 9);
    push(4'd3, 2'd2, 1'b1, b + 13);
    for (int i = 1; i <= 13; i++) begin
      step();
      chk("C_sel", int'(sel), 2);
    end

    // Mid-dwell mask change, en drop, and mask cleared while scanning.
    restart(4'b1111);
    b = cyc;
    push(4'd1, 2'd0, 1'b0, b + 5);
    repeat (7) step();
    chk("D_sel_ch1", int'(sel), 1);
    ch_mask = 4'b1101;
    step();
    chk("D_abort_sel", int'(sel), 2);
    push(4'd3, 2'd2, 1'b0, b + 12);
    push(4'd4, 2'd3, 1'b1, b + 16);
    push(4'd1, 2'd0, 1'b0, b + 20);
    push(4'd3, 2'd2, 1'b0, b + 24);
    repeat (13) step();
    chk("D_sel_before_en_drop", int'(sel), 2);
    en = 1'b0;
    repeat (13) step();
    chk("D_idle_sel", int'(sel), 2);
    en = 1'b1;
    step();
    chk("D_rescan_sel", int'(sel), 0);
    step();
    ch_mask = 4'b0000;
    repeat (9) step();
    chk("D_mask0_sel", int'(sel), 0);

    @(negedge clk);
    #1;
    chk("pending_at_end", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
